// File: rtl/keypad_conditioner.sv
// Keypad front end: synchronizes the raw enter button and digit switches, debounces
// the button, and turns each accepted press into a one-cycle enter or reject strobe.
module keypad_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter_btn,
    input  logic [3:0] in_digit,
    output logic       enter_pulse,
    output logic [3:0] digit_out,
    output logic       reject_pulse,
    output logic       btn_level
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_s1, btn_s2;
    logic [3:0]    dig_s1, dig_s2;
    logic [CW-1:0] count;
    logic          pending_rise;
    logic          digit_moving;

    assign pending_rise = btn_s2 & ~btn_level;
    // The s2 digit takes a new value at this edge; a press must see a settled digit.
    assign digit_moving = (dig_s1 != dig_s2);

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1       <= 1'b0;
            btn_s2       <= 1'b0;
            dig_s1       <= 4'd0;
            dig_s2       <= 4'd0;
            count        <= '0;
            btn_level    <= 1'b0;
            enter_pulse  <= 1'b0;
            reject_pulse <= 1'b0;
            digit_out    <= 4'd0;
        end else begin
            btn_s1       <= enter_btn;
            btn_s2       <= btn_s1;
            dig_s1       <= in_digit;
            dig_s2       <= dig_s1;
            enter_pulse  <= 1'b0;
            reject_pulse <= 1'b0;

            if ((btn_s2 == btn_level) || (pending_rise && digit_moving)) begin
                count <= '0;
            end else if (count == LAST) begin
                count     <= '0;
                btn_level <= btn_s2;
                // Only the press edge strobes; the release is silent.
                if (btn_s2) begin
                    if (dig_s2 <= 4'd9) begin
                        enter_pulse <= 1'b1;
                        digit_out   <= dig_s2;
                    end else begin
                        reject_pulse <= 1'b1;
                    end
                end
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule
